// File: rtl/gpu.sv
// Raster stage: pops draw ops from the CPU FIFO and fills clipped
// rectangles into the back framebuffer, one pixel per enabled cycle.
package gpu_pkg;
  localparam int GPU_HOR     = 640;
  localparam int GPU_VER     = 480;
  localparam int GPU_COLOR_W = 3;
  localparam int GPU_XW      = $clog2(GPU_HOR + 1);
  localparam int GPU_YW      = $clog2(GPU_VER + 1);
  localparam int GPU_AW      = $clog2(GPU_HOR * GPU_VER);

  typedef enum logic {
    OP_RECT      = 1'b0,
    OP_END_FRAME = 1'b1
  } op_kind_e;

  typedef struct packed {
    op_kind_e                 kind;
    logic [GPU_XW-1:0]        x;
    logic [GPU_YW-1:0]        y;
    logic [GPU_XW-1:0]        w;
    logic [GPU_YW-1:0]        h;
    logic [GPU_COLOR_W-1:0]   color;
  } gpu_op_t;
endpackage

module gpu
  import gpu_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = GPU_HOR,
  parameter int VER_ACTIVE_PIXELS = GPU_VER,
  parameter int COLOR_W           = GPU_COLOR_W,
  localparam int XW = $clog2(HOR_ACTIVE_PIXELS + 1),
  localparam int YW = $clog2(VER_ACTIVE_PIXELS + 1),
  localparam int AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  gpu_op_t            op,
  input  logic               op_empty,
  output logic               op_rd_en,
  input  logic               swap,
  output logic               fb_wr_en,
  output logic [AW-1:0]      fb_wr_addr,
  output logic [COLOR_W-1:0] fb_wr_data,
  output logic               status_busy,
  output logic               status_wait_swap
);

  localparam logic [XW:0]   HOR_X = (XW+1)'(HOR_ACTIVE_PIXELS);
  localparam logic [YW:0]   VER_Y = (YW+1)'(VER_ACTIVE_PIXELS);
  localparam logic [AW-1:0] HOR_A = AW'(HOR_ACTIVE_PIXELS);
  localparam logic [XW:0]   ONE_X = (XW+1)'(1);
  localparam logic [YW:0]   ONE_Y = (YW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    DRAW,
    WAIT_SWAP
  } state_t;

  state_t state;

  logic [XW-1:0]      rx, rw;
  logic [YW-1:0]      ry, rh;
  logic [COLOR_W-1:0] rcolor;

  logic [XW-1:0] col, col_last;
  logic [YW-1:0] row, row_last;
  logic [AW-1:0] row_base, addr;

  logic [XW:0]   xe_sum, xe;
  logic [YW:0]   ye_sum, ye;
  logic          empty;
  logic [AW-1:0] base_c;

  // Clip window; extra top bit keeps x+w / y+h from wrapping.
  always_comb begin
    xe_sum = {1'b0, rx} + {1'b0, rw};
    ye_sum = {1'b0, ry} + {1'b0, rh};
    xe     = (xe_sum > HOR_X) ? HOR_X : xe_sum;
    ye     = (ye_sum > VER_Y) ? VER_Y : ye_sum;
    empty  = (rw == '0) || (rh == '0) ||
             ({1'b0, rx} >= HOR_X) ||
             ({1'b0, ry} >= VER_Y);
    base_c = AW'(ry) * HOR_A;
  end

  logic drawing;
  assign drawing = (state == DRAW);

  assign op_rd_en   = !rst && ce && (state == IDLE) && !op_empty;
  assign fb_wr_en   = !rst && ce && drawing;
  assign fb_wr_addr = drawing ? addr : '0;
  assign fb_wr_data = drawing ? rcolor : '0;

  assign status_busy      = (state != IDLE);
  assign status_wait_swap = (state == WAIT_SWAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rx       <= '0;
      ry       <= '0;
      rw       <= '0;
      rh       <= '0;
      rcolor   <= '0;
      col      <= '0;
      col_last <= '0;
      row      <= '0;
      row_last <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (ce) begin
      unique case (state)
        IDLE: begin
          if (!op_empty) begin
            rx     <= op.x;
            ry     <= op.y;
            rw     <= op.w;
            rh     <= op.h;
            rcolor <= op.color;
            if (op.kind == OP_END_FRAME) state <= WAIT_SWAP;
            else                         state <= SETUP;
          end
        end
        SETUP: begin
          if (empty) begin
            state <= IDLE;
          end else begin
            col      <= rx;
            row      <= ry;
            col_last <= XW'(xe - ONE_X);
            row_last <= YW'(ye - ONE_Y);
            row_base <= base_c;
            addr     <= base_c + AW'(rx);
            state    <= DRAW;
          end
        end
        DRAW: begin
          if (col == col_last) begin
            if (row == row_last) begin
              state <= IDLE;
            end else begin
              row_base <= row_base + HOR_A;
              addr     <= row_base + HOR_A + AW'(rx);
              col      <= rx;
              row      <= row + YW'(1);
            end
          end else begin
            col  <= col + XW'(1);
            addr <= addr + AW'(1);
          end
        end
        WAIT_SWAP: begin
          if (swap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu.sv
// Bench for gpu: FIFO + pixel-list reference model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_gpu;
  import gpu_pkg::*;

  localparam int H = 640;
  localparam int V = 480;

  logic clk = 1'b0;
  logic rst, ce, swap;
  gpu_op_t op;
  logic op_empty, op_rd_en, fb_wr_en;
  logic [GPU_AW-1:0] fb_wr_addr;
  logic [GPU_COLOR_W-1:0] fb_wr_data;
  logic status_busy, status_wait_swap;

  gpu_op_t mem [256];
  int rd_ptr = 0;
  int wr_ptr = 0;

  assign op       = mem[rd_ptr[7:0]];
  assign op_empty = (rd_ptr == wr_ptr);

  gpu dut (
    .clk              (clk),
    .rst              (rst),
    .ce               (ce),
    .op               (op),
    .op_empty         (op_empty),
    .op_rd_en         (op_rd_en),
    .swap             (swap),
    .fb_wr_en         (fb_wr_en),
    .fb_wr_addr       (fb_wr_addr),
    .fb_wr_data       (fb_wr_data),
    .status_busy      (status_busy),
    .status_wait_swap (status_wait_swap)
  );

  initial forever #5 clk = ~clk;

  typedef struct {bit wr; int addr; int data;} ent_t;
  typedef struct {int cyc; int addr; int data;} wr_t;

  ent_t sched[$];
  bit   waiting = 1'b0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  wr_t wlog[$];
  int  plog[$];
  bit  busy_at[int];
  bit  wait_at[int];

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Model: a RECT costs one setup cycle then one cycle per visible pixel.
  function automatic void add_rect(input gpu_op_t o);
    int xe, ye;
    ent_t e;
    xe = int'(o.x) + int'(o.w);
    ye = int'(o.y) + int'(o.h);
    if (xe > H) xe = H;
    if (ye > V) ye = V;
    e = '{wr: 1'b0, addr: 0, data: 0};
    sched.push_back(e);
    for (int yy = int'(o.y); yy < ye; yy++)
      for (int xx = int'(o.x); xx < xe; xx++) begin
        e = '{wr: 1'b1, addr: yy * H + xx, data: int'(o.color)};
        sched.push_back(e);
      end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (op_rd_en) rd_ptr <= rd_ptr + 1;
    if (rst) begin
      sched.delete();
      waiting <= 1'b0;
    end else if (ce) begin
      if (sched.size() > 0) void'(sched.pop_front());
      else if (waiting) begin
        if (swap) waiting <= 1'b0;
      end else if (rd_ptr != wr_ptr) begin
        if (mem[rd_ptr[7:0]].kind == OP_END_FRAME) waiting <= 1'b1;
        else add_rect(mem[rd_ptr[7:0]]);
      end
    end
  end

  bit m_idle, e_rd, e_wr, m_pix;
  always @(negedge clk) begin
    m_idle = (sched.size() == 0) && !waiting;
    m_pix  = (sched.size() > 0) && sched[0].wr;
    e_rd   = !rst && ce && m_idle && (rd_ptr != wr_ptr);
    e_wr   = !rst && ce && m_pix;
    if (chk_en) begin
      chk("op_rd_en", int'(op_rd_en), int'(e_rd));
      chk("fb_wr_en", int'(fb_wr_en), int'(e_wr));
      chk("status_busy", int'(status_busy), int'(!m_idle));
      chk("status_wait_swap", int'(status_wait_swap), int'(waiting));
      if (m_pix) begin
        chk("fb_wr_addr", int'(fb_wr_addr), sched[0].addr);
        chk("fb_wr_data", int'(fb_wr_data), sched[0].data);
      end else if (m_idle) begin
        chk("idle_addr", int'(fb_wr_addr), 0);
        chk("idle_data", int'(fb_wr_data), 0);
      end
    end
    if (fb_wr_en)
      wlog.push_back('{cyc: cyc, addr: int'(fb_wr_addr), data: int'(fb_wr_data)});
    if (op_rd_en) plog.push_back(cyc);
    busy_at[cyc] = status_busy;
    wait_at[cyc] = status_wait_swap;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input bit k, input int x, input int y,
                         input int w, input int h, input int c);
    gpu_op_t t;
    t.kind  = k ? OP_END_FRAME : OP_RECT;
    t.x     = GPU_XW'(x);
    t.y     = GPU_YW'(y);
    t.w     = GPU_XW'(w);
    t.h     = GPU_YW'(h);
    t.color = GPU_COLOR_W'(c);
    mem[wr_ptr[7:0]] = t;
    wr_ptr++;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (!(rd_ptr == wr_ptr && sched.size() == 0 && !waiting) && n < max) begin
      swap = waiting && (n % 3 == 0);
      tick();
      n++;
    end
    swap = 1'b0;
    chk("drain_bound", int'(n < max), 1);
    repeat (3) tick();
  endtask

  task automatic wait_first_write(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!fb_wr_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < 20), 1);
  endtask

  task automatic clear_logs();
    wlog.delete();
    plog.delete();
  endtask

  int e2[2] = '{307198, 307199};
  int e1[4] = '{641, 642, 1281, 1282};
  int cnt, p;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    ce   = 1'b1;
    swap = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_rd_en", int'(op_rd_en), 0);
    chk("rst_fb_wr_en", int'(fb_wr_en), 0);
    chk("rst_fb_wr_addr", int'(fb_wr_addr), 0);
    chk("rst_fb_wr_data", int'(fb_wr_data), 0);
    chk("rst_busy", int'(status_busy), 0);
    chk("rst_wait_swap", int'(status_wait_swap), 0);
    tick();

    // 2x2 rectangle
    clear_logs();
    push_op(0, 1, 1, 2, 2, 5);
    drain(100);
    chk("s1_nwr", wlog.size(), 4);
    if (wlog.size() == 4 && plog.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        chk("s1_addr", wlog[i].addr, e1[i]);
        chk("s1_data", wlog[i].data, 5);
      end
      chk("s1_latency", wlog[0].cyc - plog[0], 2);
      chk("s1_busy_last", int'(busy_at[wlog[3].cyc]), 1);
      chk("s1_busy_fall", int'(busy_at[wlog[3].cyc + 1]), 0);
    end

    // bottom-right corner clip
    clear_logs();
    push_op(0, 638, 479, 4, 3, 6);
    drain(100);
    chk("s2_nwr", wlog.size(), 2);
    if (wlog.size() == 2)
      for (int i = 0; i < 2; i++) chk("s2_addr", wlog[i].addr, e2[i]);

    // fully off-screen
    clear_logs();
    push_op(0, 700, 0, 5, 5, 1);
    drain(100);
    chk("s2b_nwr", wlog.size(), 0);
    if (plog.size() == 1) begin
      chk("s2b_busy_setup", int'(busy_at[plog[0] + 1]), 1);
      chk("s2b_idle", int'(busy_at[plog[0] + 2]), 0);
    end

    // zero width then 1x1
    clear_logs();
    push_op(0, 3, 3, 0, 4, 2);
    push_op(0, 0, 0, 1, 1, 7);
    drain(100);
    chk("s3_npop", plog.size(), 2);
    if (plog.size() == 2) chk("s3_pop_gap", plog[1] - plog[0], 2);
    chk("s3_nwr", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("s3_addr", wlog[0].addr, 0);
      chk("s3_data", wlog[0].data, 7);
    end

    // END_FRAME, early swap ignored, second swap 5 cycles later
    clear_logs();
    push_op(1, 0, 0, 0, 0, 0);
    push_op(0, 5, 5, 1, 1, 2);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    repeat (4) tick();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    drain(100);
    chk("s4_npop", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("s4_pop_gap", plog[1] - plog[0], 6);
      cnt = 0;
      for (int c = plog[0]; c <= plog[0] + 10; c++) cnt += int'(wait_at[c]);
      chk("s4_wait_cycles", cnt, 5);
      chk("s4_wait_start", int'(wait_at[plog[0] + 1]), 1);
    end
    chk("s4_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("s4_addr", wlog[0].addr, 5 * H + 5);

    // ce stall after first write
    clear_logs();
    push_op(0, 10, 2, 3, 1, 3);
    wait_first_write("s5_first_bound");
    tick();
    ce = 1'b0;
    repeat (4) tick();
    ce = 1'b1;
    drain(100);
    chk("s5_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("s5_addr", wlog[i].addr, 2 * H + 10 + i);
      chk("s5_gap_stall", wlog[1].cyc - wlog[0].cyc, 5);
      chk("s5_gap_next", wlog[2].cyc - wlog[1].cyc, 1);
    end

    // reset during the second write of a 10x10
    clear_logs();
    push_op(0, 0, 0, 10, 10, 1);
    wait_first_write("s6_first_bound");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("s6_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("s6_addr", wlog[0].addr, 0);
    chk("s6_busy", int'(status_busy), 0);
    chk("s6_wr_en", int'(fb_wr_en), 0);
    chk("s6_addr_rst", int'(fb_wr_addr), 0);
    chk("s6_data_rst", int'(fb_wr_data), 0);
    tick();

    // random traffic
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      ce   = ($urandom % 10) != 0;
      swap = ($urandom % 8) == 0;
      if (cnt < 80 && ($urandom % 4) == 0 && (wr_ptr - rd_ptr) < 200) begin
        if (($urandom % 7) == 0) push_op(1, 0, 0, 0, 0, 0);
        else begin
          p = ($urandom % 4 == 0) ? int'($urandom_range(630, 700))
                                  : int'($urandom_range(0, 639));
          push_op(0, p,
                  ($urandom % 4 == 0) ? int'($urandom_range(470, 500))
                                      : int'($urandom_range(0, 479)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 7)));
        end
        cnt++;
      end
      tick();
    end
    ce = 1'b1;
    drain(5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpu.md
# gpu

Raster stage directly downstream of `cpu`. Pops `gpu_op_t` draw commands from the CPU→GPU op FIFO (the FIFO `cpu` writes through `op`/`op_wr_en`/`op_full`), rasterises solid rectangles into the back framebuffer through a single write port, and on an end-of-frame command holds until the shared `swap` pulse. One pixel per enabled cycle, no multipliers in the datapath.

## Interface
- `HOR_ACTIVE_PIXELS`, 640, framebuffer width in pixels
- `VER_ACTIVE_PIXELS`, 480, framebuffer height in pixels
- `COLOR_W`, 3, pixel colour width
- Derived: `XW = $clog2(HOR_ACTIVE_PIXELS+1)`, `YW = $clog2(VER_ACTIVE_PIXELS+1)`, `AW = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)`

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `ce` in 1: clock enable; when low, all state holds and no strobes fire
- `op` in `gpu_op_t`: FIFO head, first-word-fall-through; fields `kind` (0 = RECT, 1 = END_FRAME), `x[XW]`, `y[YW]`, `w[XW]`, `h[YW]`, `color[COLOR_W]`
- `op_empty` in 1: FIFO empty
- `op_rd_en` out 1: pop strobe; head is consumed at the same edge
- `swap` in 1: one-cycle buffer-swap pulse (same net as `cpu.swap`)
- `fb_wr_en` out 1: framebuffer write strobe
- `fb_wr_addr` out AW: linear address `y*HOR_ACTIVE_PIXELS + x`
- `fb_wr_data` out COLOR_W: pixel colour
- `status_busy` out 1: high in any state other than IDLE
- `status_wait_swap` out 1: high in WAIT_SWAP

## Operation
- FSM states: IDLE, SETUP, DRAW, WAIT_SWAP. Reset → IDLE.
- IDLE: `op_rd_en = ce && !op_empty` (combinational). On a pop, latch `op`. RECT → SETUP; END_FRAME → WAIT_SWAP.
- SETUP (1 cycle): clip to the screen.
  - `xe = min(x+w, HOR)`, `ye = min(y+h, VER)`, computed at XW+1 / YW+1 bits so there is no overflow.
  - Empty if `w==0`, `h==0`, `x>=HOR` or `y>=VER`; empty → IDLE with no writes.
  - Otherwise load column = x, row = y, `row_base = y*HOR` (one constant multiply, registered here only), `addr = row_base + x`; → DRAW.
- DRAW: `fb_wr_en = ce`, `fb_wr_addr = addr`, `fb_wr_data = color`. Raster order, left to right then top to bottom.
  - At the end of a row: `row_base += HOR`, `addr = row_base + x`, `row++`.
  - After pixel (xe-1, ye-1) → IDLE.
- WAIT_SWAP: no pops, no writes. On `swap && ce` → IDLE. `swap` in any other state is ignored, including the cycle END_FRAME is popped.
- `ce` low: FSM, counters and latched op hold. `op_rd_en` and `fb_wr_en` are forced to 0. `swap` is not captured.
- Reset mid-operation: next state is IDLE, all counters cleared, latched op discarded. No pop or write occurs in the reset cycle.

## Timing
- Reset values: `op_rd_en=0`, `fb_wr_en=0`, `fb_wr_addr=0`, `fb_wr_data=0`, `status_busy=0`, `status_wait_swap=0`.
- RECT popped at edge t:
  - SETUP during cycle t+1.
  - First write during cycle t+2.
  - Clipped area N pixels takes N consecutive write cycles.
  - Next pop is possible in the cycle after the last write.
  - Total op cost is N+2 cycles (ce high).
- Empty/fully clipped RECT: 2 cycles, zero writes.
- END_FRAME popped at edge t: `status_wait_swap` high from cycle t+1. A `swap` sampled at edge s returns the FSM to IDLE; the earliest pop is in cycle s+1.
- `fb_wr_*` are combinational from registered state; the framebuffer samples them at the same edge as `fb_wr_en`.

## Test plan
- RECT x=1 y=1 w=2 h=2 color=5 → writes exactly at addr 641, 642, 1281, 1282 with data 5; first write 2 cycles after pop; `status_busy` falls after the 4th write.
- RECT x=638 y=479 w=4 h=3 → only addr 307198, 307199 written. RECT x=700 y=0 w=5 h=5 → zero writes, back in IDLE 2 cycles after pop.
- RECT w=0 followed immediately by RECT x=0 y=0 w=1 h=1 color=7 → one write at addr 0 with data 7; second pop exactly 2 cycles after the first.
- END_FRAME then RECT queued, with `swap` pulsed in the pop cycle and again 5 cycles later → `op_rd_en` stays 0 until the second pulse; RECT pop in the cycle after it; `status_wait_swap` high for exactly 5 cycles.
- RECT w=3 h=1 with `ce` low for 4 cycles after the first write → no strobes while `ce` low; remaining addresses continue without gaps or repeats.
- `rst` asserted during the 2nd write of a 10x10 RECT → `fb_wr_en` 0 in the reset cycle, then IDLE with all outputs at reset values; remaining pixels never written.
